// File: rtl/pe_pkg.sv
// Shared definitions for the row-stationary PE: FSM encoding and sizing helpers.
package pe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_IACT,
    LD_WGT,
    INIT,
    MAC,
    OUT
  } pe_state_e;

  function automatic int out_size(input int iact, input int kernel, input int stride);
    return (iact - kernel) / stride + 1;
  endfunction

  // Bits needed to index 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Signed multiply-accumulate slice with clear and parallel-load controls.
module pe_mac
  import pe_pkg::*;
#(
  parameter int D_WIDTH   = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        load,
  input  logic signed [ACC_WIDTH-1:0] load_value,
  input  logic                        mac_en,
  input  logic signed [D_WIDTH-1:0]   a,
  input  logic signed [D_WIDTH-1:0]   b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [2*D_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0] product_ext;

  assign product     = (2*D_WIDTH)'(a) * (2*D_WIDTH)'(b);
  // Size cast of a signed value sign-extends; the sum wraps naturally.
  assign product_ext = ACC_WIDTH'(product);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_value;
    end else if (mac_en) begin
      acc <= acc + product_ext;
    end
  end

endmodule

// File: rtl/pe_row_mf.sv
// Row-stationary PE: buffers an iact row and NUM_FILTERS weight rows, then streams
// one strided sliding-window psum per (filter, output position).
module pe_row_mf
  import pe_pkg::*;
#(
  parameter int D_WIDTH     = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int IACT_SIZE   = 5,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_FILTERS = 2,
  parameter int STRIDE      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 acc_en,
  input  logic [D_WIDTH-1:0]   iact_in,
  input  logic                 iact_valid,
  input  logic [D_WIDTH-1:0]   weight_in,
  input  logic                 weight_valid,
  input  logic [ACC_WIDTH-1:0] psum_in,
  input  logic                 psum_in_valid,
  output logic                 psum_in_ready,
  output logic [ACC_WIDTH-1:0] psum_out,
  output logic                 psum_out_valid,
  input  logic                 psum_out_ready,
  output logic                 load_iact,
  output logic                 load_weight,
  output logic                 busy,
  output logic                 done
);

  localparam int OUT_SIZE = out_size(IACT_SIZE, KERNEL_SIZE, STRIDE);
  localparam int NUM_WGT  = NUM_FILTERS * KERNEL_SIZE;
  localparam int IAW      = cnt_width(IACT_SIZE);
  localparam int WW       = cnt_width(NUM_WGT);
  localparam int KW       = cnt_width(KERNEL_SIZE);
  localparam int OW       = cnt_width(OUT_SIZE);
  localparam int FW       = cnt_width(NUM_FILTERS);

  pe_state_e state, next_state;

  logic                      acc_en_r;
  logic signed [D_WIDTH-1:0] iact_buf [IACT_SIZE];
  logic signed [D_WIDTH-1:0] wgt_buf  [NUM_WGT];
  logic [IAW-1:0]            iact_cnt;
  logic [WW-1:0]             wgt_cnt;
  logic [KW-1:0]             k_cnt;
  logic [OW-1:0]             o_cnt;
  logic [FW-1:0]             f_cnt;
  logic [IAW-1:0]            iact_idx;
  logic [WW-1:0]             wgt_idx;

  logic iact_last, wgt_last, k_last, o_last, f_last;
  logic iact_accept, wgt_accept, out_fire;
  logic mac_clear, mac_load, mac_en;
  logic signed [ACC_WIDTH-1:0] acc;

  assign iact_last   = (iact_cnt == IAW'(IACT_SIZE - 1));
  assign wgt_last    = (wgt_cnt  == WW'(NUM_WGT - 1));
  assign k_last      = (k_cnt    == KW'(KERNEL_SIZE - 1));
  assign o_last      = (o_cnt    == OW'(OUT_SIZE - 1));
  assign f_last      = (f_cnt    == FW'(NUM_FILTERS - 1));
  assign iact_accept = (state == LD_IACT) && iact_valid;
  assign wgt_accept  = (state == LD_WGT) && weight_valid;
  assign out_fire    = (state == OUT) && psum_out_ready;

  assign iact_idx = IAW'(int'(o_cnt) * STRIDE + int'(k_cnt));
  assign wgt_idx  = WW'(int'(f_cnt) * KERNEL_SIZE + int'(k_cnt));

  assign busy     = (state != IDLE);
  assign psum_out = psum_out_valid ? acc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    psum_in_ready  = 1'b0;
    psum_out_valid = 1'b0;
    load_iact      = 1'b0;
    load_weight    = 1'b0;
    done           = 1'b0;
    mac_clear      = 1'b0;
    mac_load       = 1'b0;
    mac_en         = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = LD_IACT;
      end
      LD_IACT: begin
        if (iact_valid && iact_last) begin
          load_iact  = 1'b1;
          next_state = LD_WGT;
        end
      end
      LD_WGT: begin
        if (weight_valid && wgt_last) begin
          load_weight = 1'b1;
          next_state  = INIT;
        end
      end
      INIT: begin
        // Accumulating windows wait here for the psum from the PE below.
        if (acc_en_r) begin
          psum_in_ready = 1'b1;
          if (psum_in_valid) begin
            mac_load   = 1'b1;
            next_state = MAC;
          end
        end else begin
          mac_clear  = 1'b1;
          next_state = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_last) next_state = OUT;
      end
      OUT: begin
        psum_out_valid = 1'b1;
        if (psum_out_ready) begin
          if (f_last && o_last) begin
            done       = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = INIT;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_en_r <= 1'b0;
      iact_cnt <= '0;
      wgt_cnt  <= '0;
      k_cnt    <= '0;
      o_cnt    <= '0;
      f_cnt    <= '0;
    end else begin
      if (state == IDLE && start) begin
        acc_en_r <= acc_en;
        iact_cnt <= '0;
        wgt_cnt  <= '0;
        k_cnt    <= '0;
        o_cnt    <= '0;
        f_cnt    <= '0;
      end
      if (iact_accept) iact_cnt <= iact_last ? '0 : iact_cnt + 1'b1;
      if (wgt_accept)  wgt_cnt  <= wgt_last  ? '0 : wgt_cnt + 1'b1;
      if (state == MAC) k_cnt <= k_last ? '0 : k_cnt + 1'b1;
      // Output order is filter-major: o sweeps fully before f advances.
      if (out_fire) begin
        if (o_last) begin
          o_cnt <= '0;
          f_cnt <= f_last ? '0 : f_cnt + 1'b1;
        end else begin
          o_cnt <= o_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (iact_accept) iact_buf[iact_cnt] <= iact_in;
    if (wgt_accept)  wgt_buf[wgt_cnt]   <= weight_in;
  end

  pe_mac #(
    .D_WIDTH  (D_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clear     (mac_clear),
    .load      (mac_load),
    .load_value($signed(psum_in)),
    .mac_en    (mac_en),
    .a         (iact_buf[iact_idx]),
    .b         (wgt_buf[wgt_idx]),
    .acc       (acc)
  );

endmodule

// File: tb/tb_pe_row_mf.sv
// Directed self-checking bench for pe_row_mf (default and STRIDE=2 instances).
module tb_pe_row_mf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_s2 = 1'b0;
  logic        acc_en = 1'b0;
  logic [15:0] iact_in = '0;
  logic        iact_valid = 1'b0;
  logic [15:0] weight_in = '0;
  logic        weight_valid = 1'b0;
  logic [31:0] psum_in = '0;
  logic        psum_in_valid = 1'b0;
  logic        psum_out_ready = 1'b1;

  logic [31:0] psum_out, psum_out_s2;
  logic psum_in_ready, psum_out_valid, load_iact, load_weight, busy, done;
  logic psum_in_ready_s2, psum_out_valid_s2, load_iact_s2, load_weight_s2, busy_s2, done_s2;

  bit          sel_s2 = 1'b0;
  logic [31:0] sel_psum;
  logic sel_valid, sel_in_ready, sel_li, sel_lw, sel_busy, sel_done;

  assign sel_psum     = sel_s2 ? psum_out_s2       : psum_out;
  assign sel_valid    = sel_s2 ? psum_out_valid_s2 : psum_out_valid;
  assign sel_in_ready = sel_s2 ? psum_in_ready_s2  : psum_in_ready;
  assign sel_li       = sel_s2 ? load_iact_s2      : load_iact;
  assign sel_lw       = sel_s2 ? load_weight_s2    : load_weight;
  assign sel_busy     = sel_s2 ? busy_s2           : busy;
  assign sel_done     = sel_s2 ? done_s2           : done;

  always #5 clk = ~clk;

  pe_row_mf dut (
    .clk(clk), .rst(rst), .start(start), .acc_en(acc_en),
    .iact_in(iact_in), .iact_valid(iact_valid),
    .weight_in(weight_in), .weight_valid(weight_valid),
    .psum_in(psum_in), .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready),
    .psum_out(psum_out), .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready),
    .load_iact(load_iact), .load_weight(load_weight), .busy(busy), .done(done)
  );

  pe_row_mf #(.STRIDE(2)) dut_s2 (
    .clk(clk), .rst(rst), .start(start_s2), .acc_en(acc_en),
    .iact_in(iact_in), .iact_valid(iact_valid),
    .weight_in(weight_in), .weight_valid(weight_valid),
    .psum_in(psum_in), .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready_s2),
    .psum_out(psum_out_s2), .psum_out_valid(psum_out_valid_s2), .psum_out_ready(psum_out_ready),
    .load_iact(load_iact_s2), .load_weight(load_weight_s2), .busy(busy_s2), .done(done_s2)
  );

  int vectors = 0;
  int miscompares = 0;

  int iact_vec [5] = '{2, 4, 6, 8, 10};
  int wgt_vec  [6] = '{1, 2, 3, -1, 0, 1};
  int exp_base [6] = '{28, 40, 52, 4, 4, 4};
  int exp_s2   [4] = '{28, 52, 4, 4};
  int exp_acc  [6] = '{128, 140, 152, 104, 104, 104};

  logic [31:0] got_val [16];
  int got_cyc [16];
  int n_got, done_cnt, done_idx, stall_ready, hold_cycles, hold_bad, n_li, n_lw;
  bit timed_out;

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic do_load(input bit gapped, input bit restart);
    n_li = 0;
    n_lw = 0;
    if (sel_s2) start_s2 = 1'b1; else start = 1'b1;
    acc_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; start_s2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (gapped) begin
        iact_valid = 1'b0; weight_valid = 1'b1; weight_in = 16'd99;
        if (restart && i == 2) begin
          if (sel_s2) start_s2 = 1'b1; else start = 1'b1;
          acc_en = 1'b1;
        end
        @(negedge clk);
        if (sel_li) n_li++;
        if (sel_lw) n_lw++;
        @(posedge clk); #1;
        start = 1'b0; start_s2 = 1'b0; acc_en = 1'b0;
      end
      iact_valid = 1'b1; iact_in = 16'(iact_vec[i]); weight_valid = 1'b0;
      @(negedge clk);
      if (sel_li) n_li++;
      if (sel_lw) n_lw++;
      @(posedge clk); #1;
    end
    iact_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (gapped) begin
        weight_valid = 1'b0; iact_valid = 1'b1; iact_in = 16'd99;
        if (restart && i == 3) begin
          if (sel_s2) start_s2 = 1'b1; else start = 1'b1;
          acc_en = 1'b1;
        end
        @(negedge clk);
        if (sel_li) n_li++;
        if (sel_lw) n_lw++;
        @(posedge clk); #1;
        start = 1'b0; start_s2 = 1'b0; acc_en = 1'b0;
      end
      weight_valid = 1'b1; weight_in = 16'(wgt_vec[i]); iact_valid = 1'b0;
      @(negedge clk);
      if (sel_li) n_li++;
      if (sel_lw) n_lw++;
      @(posedge clk); #1;
    end
    weight_valid = 1'b0;
  endtask

  task automatic do_load_acc();
    if (sel_s2) start_s2 = 1'b1; else start = 1'b1;
    acc_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_s2 = 1'b0; acc_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iact_valid = 1'b1; iact_in = 16'(iact_vec[i]);
      @(posedge clk); #1;
    end
    iact_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      weight_valid = 1'b1; weight_in = 16'(wgt_vec[i]);
      @(posedge clk); #1;
    end
    weight_valid = 1'b0;
  endtask

  // Cycle 0 is the first INIT cycle; records each handshake value and cycle.
  task automatic collect(input int n_exp, input int psum_val, input int delay0,
                         input int bp_idx, input int bp_len);
    int cyc;
    int bp_left;
    logic [31:0] held;
    bit holding;
    n_got = 0; done_cnt = 0; done_idx = -1; stall_ready = 0;
    hold_cycles = 0; hold_bad = 0; timed_out = 1'b0;
    bp_left = bp_len; holding = 1'b0; held = '0; cyc = 0;
    while (n_got < n_exp && !timed_out) begin
      psum_in = 32'(psum_val);
      psum_in_valid = (cyc >= delay0);
      psum_out_ready = 1'b1;
      if (sel_valid && n_got == bp_idx && bp_left > 0) begin
        psum_out_ready = 1'b0;
        bp_left--;
      end
      @(negedge clk);
      if (cyc < delay0 && sel_in_ready) stall_ready++;
      if (sel_done) begin
        done_cnt++;
        done_idx = n_got;
      end
      if (sel_valid) begin
        if (holding && sel_psum !== held) hold_bad++;
        if (psum_out_ready) begin
          got_val[n_got] = sel_psum;
          got_cyc[n_got] = cyc;
          n_got++;
          holding = 1'b0;
        end else begin
          hold_cycles++;
          held = sel_psum;
          holding = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 400) timed_out = 1'b1;
    end
    psum_in_valid = 1'b0;
    psum_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if ({busy, psum_out_valid, psum_in_ready, load_iact, load_weight, done} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {busy, psum_out_valid, psum_in_ready, load_iact, load_weight, done});
    end
    vectors++;
    if (psum_out !== 32'd0 || psum_out_s2 !== 32'd0 || busy_s2 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_psum: got %0d/%0d busy_s2=%b expected 0/0 busy_s2=0",
               psum_out, psum_out_s2, busy_s2);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release_busy: got %b expected 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    sel_s2 = 1'b0;
    do_load(1'b0, 1'b0);
    collect(6, 0, 0, -1, 0);
    vectors++;
    if (timed_out || n_got != 6) begin
      miscompares++;
      $display("[TB] FAIL basic_count: got %0d outputs expected 6", n_got);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (got_val[i] !== 32'(exp_base[i])) begin
        miscompares++;
        $display("[TB] FAIL basic_out[%0d]: got %0d expected %0d", i, $signed(got_val[i]), exp_base[i]);
      end
    end
    vectors++;
    if (got_cyc[0] != 4) begin
      miscompares++;
      $display("[TB] FAIL basic_first_latency: got %0d expected 4", got_cyc[0]);
    end
    for (int i = 1; i < 6; i++) begin
      vectors++;
      if (got_cyc[i] - got_cyc[i-1] != 5) begin
        miscompares++;
        $display("[TB] FAIL basic_spacing[%0d]: got %0d expected 5", i, got_cyc[i] - got_cyc[i-1]);
      end
    end
    vectors++;
    if (done_cnt != 1 || done_idx != 5) begin
      miscompares++;
      $display("[TB] FAIL basic_done: got count %0d at %0d expected count 1 at 5", done_cnt, done_idx);
    end
    vectors++;
    if (sel_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_idle_after: got busy %b expected 0", sel_busy);
    end
  endtask

  task automatic test_stride2();
    sel_s2 = 1'b1;
    do_load(1'b0, 1'b0);
    collect(4, 0, 0, -1, 0);
    vectors++;
    if (timed_out || n_got != 4) begin
      miscompares++;
      $display("[TB] FAIL s2_count: got %0d outputs expected 4", n_got);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_val[i] !== 32'(exp_s2[i])) begin
        miscompares++;
        $display("[TB] FAIL s2_out[%0d]: got %0d expected %0d", i, $signed(got_val[i]), exp_s2[i]);
      end
    end
    vectors++;
    if (done_cnt != 1 || done_idx != 3) begin
      miscompares++;
      $display("[TB] FAIL s2_done: got count %0d at %0d expected count 1 at 3", done_cnt, done_idx);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL s2_other_idle: got busy %b expected 0", busy);
    end
    sel_s2 = 1'b0;
  endtask

  task automatic test_accumulate();
    sel_s2 = 1'b0;
    do_load_acc();
    collect(6, 100, 3, -1, 0);
    vectors++;
    if (timed_out || n_got != 6) begin
      miscompares++;
      $display("[TB] FAIL acc_count: got %0d outputs expected 6", n_got);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (got_val[i] !== 32'(exp_acc[i])) begin
        miscompares++;
        $display("[TB] FAIL acc_out[%0d]: got %0d expected %0d", i, $signed(got_val[i]), exp_acc[i]);
      end
    end
    vectors++;
    if (stall_ready != 3) begin
      miscompares++;
      $display("[TB] FAIL acc_stall_ready: got %0d cycles expected 3", stall_ready);
    end
    vectors++;
    if (got_cyc[0] != 7 || got_cyc[1] != 12) begin
      miscompares++;
      $display("[TB] FAIL acc_latency: got %0d,%0d expected 7,12", got_cyc[0], got_cyc[1]);
    end
    vectors++;
    if (done_cnt != 1 || done_idx != 5) begin
      miscompares++;
      $display("[TB] FAIL acc_done: got count %0d at %0d expected count 1 at 5", done_cnt, done_idx);
    end
  endtask

  task automatic test_backpressure();
    sel_s2 = 1'b0;
    do_load(1'b0, 1'b0);
    collect(6, 0, 0, 2, 4);
    vectors++;
    if (timed_out || n_got != 6) begin
      miscompares++;
      $display("[TB] FAIL bp_count: got %0d outputs expected 6", n_got);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (got_val[i] !== 32'(exp_base[i])) begin
        miscompares++;
        $display("[TB] FAIL bp_out[%0d]: got %0d expected %0d", i, $signed(got_val[i]), exp_base[i]);
      end
    end
    vectors++;
    if (hold_cycles != 4 || hold_bad != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_hold: got %0d cycles %0d changes expected 4 cycles 0 changes",
               hold_cycles, hold_bad);
    end
    vectors++;
    if (got_cyc[2] != 18 || got_cyc[3] != 23) begin
      miscompares++;
      $display("[TB] FAIL bp_timing: got %0d,%0d expected 18,23", got_cyc[2], got_cyc[3]);
    end
  endtask

  task automatic test_gapped_load();
    sel_s2 = 1'b0;
    do_load(1'b1, 1'b1);
    vectors++;
    if (n_li != 1 || n_lw != 1) begin
      miscompares++;
      $display("[TB] FAIL gap_load_pulses: got %0d/%0d expected 1/1", n_li, n_lw);
    end
    // A psum is offered; it must be ignored since acc_en was 0 at the honoured start.
    collect(6, 1000, 0, -1, 0);
    vectors++;
    if (timed_out || n_got != 6) begin
      miscompares++;
      $display("[TB] FAIL gap_count: got %0d outputs expected 6", n_got);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (got_val[i] !== 32'(exp_base[i])) begin
        miscompares++;
        $display("[TB] FAIL gap_out[%0d]: got %0d expected %0d", i, $signed(got_val[i]), exp_base[i]);
      end
    end
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("[TB] FAIL gap_done: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid_pass();
    sel_s2 = 1'b0;
    do_load(1'b0, 1'b0);
    collect(1, 0, 0, -1, 0);
    vectors++;
    if (n_got != 1 || got_val[0] !== 32'd28) begin
      miscompares++;
      $display("[TB] FAIL rstmid_first: got %0d expected 28", $signed(got_val[0]));
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_in_mac: got busy %b expected 1", busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || psum_out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_abort: got busy %b valid %b expected 0 0", busy, psum_out_valid);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || psum_out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rstmid_stays_idle: got busy %b valid %b expected 0 0", busy, psum_out_valid);
      end
      @(posedge clk); #1;
    end
    do_load(1'b0, 1'b0);
    collect(6, 0, 0, -1, 0);
    vectors++;
    if (timed_out || n_got != 6) begin
      miscompares++;
      $display("[TB] FAIL rstmid_rerun_count: got %0d outputs expected 6", n_got);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (got_val[i] !== 32'(exp_base[i])) begin
        miscompares++;
        $display("[TB] FAIL rstmid_rerun_out[%0d]: got %0d expected %0d", i, $signed(got_val[i]), exp_base[i]);
      end
    end
    vectors++;
    if (done_cnt != 1 || done_idx != 5) begin
      miscompares++;
      $display("[TB] FAIL rstmid_rerun_done: got count %0d at %0d expected count 1 at 5", done_cnt, done_idx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride2();
    test_accumulate();
    test_backpressure();
    test_gapped_load();
    test_reset_mid_pass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
